// File: rtl/noc_acc_pkg.sv
// Shared definitions for the NoC accumulator bank.
//   acc_state_e : bank FSM encoding (IDLE / RUN / DRAIN)
//   LOG_N_ADD   : default log2 lane count, N_LANE = 2**LOG_N_ADD
//   sext()      : sign-extend the low w bits of a SEXT_W-bit value
package noc_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } acc_state_e;

  localparam int LOG_N_ADD = 6;
  localparam int N_LANE    = 2**LOG_N_ADD;
  localparam int SEXT_W    = 64;

  // Left-justify the field, then arithmetic shift back down.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                             input int unsigned       w);
    logic signed [SEXT_W-1:0] t;
    t = signed'(v << (SEXT_W - w));
    return unsigned'(t >>> (SEXT_W - w));
  endfunction

endpackage

// File: rtl/noc_acc_lane.sv
// One accumulator lane: sums signed terms until len terms have arrived.
//   clk, rst     : clock, async active-low reset
//   i_clear      : job start, clears acc/cnt/done/emitted
//   i_run        : bank is in RUN, terms may be accepted
//   i_val/i_data : term valid and signed term
//   i_len        : terms per lane for this job
//   i_emit       : result register is taking this lane's sum
//   o_done       : all terms received
//   o_emitted    : sum already handed to the result register
//   o_acc        : running / final sum
//   o_err_hit    : a term arrived for an already-completed lane
module noc_acc_lane
  import noc_acc_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int acc_width = 24,
  parameter int cnt_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_run,
  input  logic                 i_val,
  input  logic [bit_width-1:0] i_data,
  input  logic [cnt_width-1:0] i_len,
  input  logic                 i_emit,
  output logic                 o_done,
  output logic                 o_emitted,
  output logic [acc_width-1:0] o_acc,
  output logic                 o_err_hit
);

  logic [acc_width-1:0] r_acc;
  logic [cnt_width-1:0] r_cnt;
  logic                 r_done;
  logic                 r_emitted;

  logic [acc_width-1:0] w_term;
  logic [cnt_width-1:0] w_cnt_nx;
  logic                 w_take;

  assign w_term   = acc_width'(sext({{(SEXT_W-bit_width){1'b0}}, i_data}, bit_width));
  assign w_take   = i_run & i_val & ~r_done;
  assign w_cnt_nx = r_cnt + cnt_width'(1);

  assign o_err_hit = i_val & (r_done | r_emitted);
  assign o_done    = r_done;
  assign o_emitted = r_emitted;
  assign o_acc     = r_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_emitted <= 1'b0;
    end else if (i_clear) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_emitted <= 1'b0;
    end else begin
      if (w_take) begin
        r_acc <= r_acc + w_term;  // wraps modulo 2**acc_width
        r_cnt <= w_cnt_nx;
        if (w_cnt_nx == i_len) r_done <= 1'b1;
      end
      if (i_emit) r_emitted <= 1'b1;
    end
  end

endmodule

// File: rtl/noc_acc_bank.sv
// NoC adder-stage accumulator bank: per-lane signed accumulation over a
// job of len terms, results serialised lowest lane first on one
// valid/ready port.
//   clk, rst            : clock, async active-low reset
//   in_data/in_val      : per-lane terms (lane i at [i*bit_width +: bit_width])
//   start/len           : job start and terms per lane (sampled in IDLE)
//   res_data/res_idx    : finished sum and its lane
//   res_valid/res_ready : result handshake
//   busy                : job in RUN or DRAIN
//   job_done            : one-cycle pulse after the final result pops
//   err                 : sticky, term arrived in IDLE or for a completed lane
module noc_acc_bank
  import noc_acc_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int log_n_add = LOG_N_ADD,
  parameter int acc_width = 24,
  parameter int cnt_width = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [bit_width*(2**log_n_add)-1:0] in_data,
  input  logic [(2**log_n_add)-1:0]       in_val,
  input  logic                            start,
  input  logic [cnt_width-1:0]            len,
  output logic [acc_width-1:0]            res_data,
  output logic [log_n_add-1:0]            res_idx,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            busy,
  output logic                            job_done,
  output logic                            err
);

  localparam int NL = 2**log_n_add;

  acc_state_e r_state, w_state_nx;

  logic [cnt_width-1:0]          r_len;
  logic [acc_width-1:0]          r_res_data;
  logic [log_n_add-1:0]          r_res_idx;
  logic                          r_res_valid;
  logic                          r_job_done;
  logic                          r_err;

  logic                          w_clear;
  logic                          w_run;
  logic                          w_job_done_nx;
  logic [NL-1:0]                 w_done, w_emitted, w_err_hit, w_pend, w_emit;
  logic [NL-1:0][acc_width-1:0]  w_acc;
  logic [log_n_add-1:0]          w_sel;
  logic                          w_any;
  logic                          w_load, w_pop;
  logic                          w_all_done, w_all_emit;
  logic                          w_err_set;

  assign w_run = (r_state == ST_RUN);

  // ---------------- lanes ----------------
  for (genvar g = 0; g < NL; g++) begin : g_lane
    noc_acc_lane #(
      .bit_width (bit_width),
      .acc_width (acc_width),
      .cnt_width (cnt_width)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_clear),
      .i_run     (w_run),
      .i_val     (in_val[g]),
      .i_data    (in_data[g*bit_width +: bit_width]),
      .i_len     (r_len),
      .i_emit    (w_emit[g]),
      .o_done    (w_done[g]),
      .o_emitted (w_emitted[g]),
      .o_acc     (w_acc[g]),
      .o_err_hit (w_err_hit[g])
    );
    assign w_pend[g] = w_done[g] & ~w_emitted[g];
    assign w_emit[g] = w_load & w_any & (w_sel == log_n_add'(g));
  end

  assign w_all_done = &w_done;
  assign w_all_emit = &w_emitted;

  // Lowest pending lane wins; scan high to low so the last hit is the lowest.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = NL-1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_sel = log_n_add'(i);
        w_any = 1'b1;
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_clear       = 1'b0;
    w_job_done_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          w_state_nx = ST_RUN;
          w_clear    = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_all_done) w_state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Once every lane is emitted the register holds the last sum.
        if (w_all_emit && w_pop) begin
          w_state_nx    = ST_IDLE;
          w_job_done_nx = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // ---------------- result register ----------------
  assign w_pop  = r_res_valid & res_ready;
  assign w_load = ~r_res_valid | res_ready;

  // The start cycle is still IDLE, so a term there counts as an IDLE term.
  assign w_err_set = (r_state == ST_IDLE) ? (|in_val) : (|w_err_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len       <= '0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
      r_res_valid <= 1'b0;
      r_job_done  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_clear) r_len <= len;
      if (w_load) begin
        if (w_any) begin
          r_res_valid <= 1'b1;
          r_res_data  <= w_acc[w_sel];
          r_res_idx   <= w_sel;
        end else begin
          r_res_valid <= 1'b0;
        end
      end
      r_job_done <= w_job_done_nx;
      r_err      <= (w_clear ? 1'b0 : r_err) | w_err_set;
    end
  end

  assign res_data  = r_res_data;
  assign res_idx   = r_res_idx;
  assign res_valid = r_res_valid;
  assign busy      = (r_state != ST_IDLE);
  assign job_done  = r_job_done;
  assign err       = r_err;

endmodule
